pixel_readout_fifo: RTL and testbench
=====================================

# pixel_readout_fifo

Buffers digitised pixel samples downstream of the pixel array readout. It captures the two 16-bit data buses during the `read_1` and `read_2` phases driven by the pixel state machine and pairs them into one 32-bit word per frame. Each word is pushed into a small FIFO tagged with a frame number. A consumer drains the FIFO through a valid/ready handshake.

## Interface
- `DEPTH`, 8 — FIFO entries; power of two, minimum 2.
- `FRAME_W`, 8 — width of the frame tag.
- `clk` in 1 — single clock; all logic updates on the rising edge.
- `reset` in 1 — synchronous, active-high.
- `read_1` in 1 — pixel phase-1 read strobe, from the pixel state machine.
- `read_2` in 1 — pixel phase-2 read strobe.
- `pixdata1` in 16 — bus value during `read_1`.
- `pixdata2` in 16 — bus value during `read_2`.
- `out_data` out 32 — head word: {p2, p1}.
- `out_frame` out FRAME_W — frame tag of the head word.
- `out_valid` out 1 — head entry present.
- `out_ready` in 1 — consumer accepts the head word.
- `full` out 1 — FIFO holds DEPTH entries.
- `overflow` out 1 — sticky; a pair was dropped while the FIFO was full.
- `seq_err` out 1 — one-cycle pulse on a read-phase ordering violation.

## Operation
- **Edge detection**
  - `r1_d` and `r2_d` are registered copies of `read_1` and `read_2`.
  - A fall of `read_x` is an edge where `r_x_d=1` and `read_x=0`.
- **Hold registers**
  - `h1` loads `pixdata1` on every edge where `read_1=1`.
  - `h2` loads `pixdata2` on every edge where `read_2=1`.
  - Each therefore holds the last sample of its phase.
- **State machine** (two states)
  - IDLE, on fall of `read_1`: latch `p1<=h1`, go to HAVE_P1.
  - IDLE, on fall of `read_2`: pulse `seq_err`, no push, stay in IDLE.
  - HAVE_P1, on fall of `read_2`: push {h2, p1} with tag `frame_cnt`, increment `frame_cnt` (modulo 2^FRAME_W), go to IDLE.
  - HAVE_P1, on fall of `read_1`: pulse `seq_err`, overwrite `p1<=h1`, stay in HAVE_P1.
  - Both falls on the same edge, from either state: pulse `seq_err`, push nothing, go to IDLE.
- **FIFO**
  - Circular buffer with `log2(DEPTH)`-bit read and write pointers plus a count of `log2(DEPTH)+1` bits.
  - Pop occurs when `out_valid && out_ready`.
  - Push is accepted if `count<DEPTH` or a pop happens on the same edge.
  - A rejected push drops the pair and sets `overflow`. `frame_cnt` still increments, so the gap is visible in the tags.
  - Simultaneous push and pop leaves count unchanged.
  - Pop when empty is ignored.
- **Output registers**
  - `out_data` and `out_frame` present the entry at the read pointer.
  - `out_valid = (count!=0)`.
  - `full = (count==DEPTH)`.
  - Both flags are registered from count, never combinational from inputs.
- **Reset**
  - Reset asserted at any time returns state to IDLE and clears `h1`, `h2`, `p1`, pointers, count, `frame_cnt`, `r1_d` and `r2_d`.
  - Reset clears `overflow` and `seq_err`.
  - Any in-flight pair is discarded.

## Timing
- Reset values: `out_data=0`, `out_frame=0`, `out_valid=0`, `full=0`, `overflow=0`, `seq_err=0`.
- A push happens at the first edge sampling `read_2=0` after `read_2` was high.
- Into an empty FIFO, `out_valid` is high the cycle after the push edge (latency 1).
- `out_data` is stable while `out_valid=1 && out_ready=0`.
- After a pop, the next entry appears the following cycle; there is no bubble when count>1.
- `seq_err` is high exactly one cycle per violation.
- `overflow` stays high until reset.
- Throughput: at most one push per cycle. The FSM's c_read spacing makes one push per frame the norm.

## Configuration
- `PIXEL_FIFO_DROP_CNT_EN`
- **Defined:**
  - Adds output `drop_cnt`, 16 bits, reset 0.
  - `drop_cnt` increments on every rejected push.
  - It saturates at 16'hFFFF.
- **Undefined:**
  - The port and counter are absent.
  - `overflow` is the only drop indication.

## Test plan
- **Basic frame.** Reset. Then: `read_1` high 5 cycles with `pixdata1=16'h1234`, low; then `read_2` high 5 cycles with `pixdata2=16'hABCD`, low; `out_ready=0`.
  - Required: `out_valid=1` one cycle after the `read_2` fall.
  - Required: `out_data=32'hABCD1234`, `out_frame=0`.
- **Last-sample hold.** `pixdata1` ramps 0, 257, 514 during `read_1`.
  - Required: `out_data[15:0]=514`.
- **Fill to full.** Push DEPTH=8 frames with `out_ready=0`.
  - Required: `full=1`.
  - Push a ninth frame: `overflow=1`, the head is still frame 0, and the next accepted word carries tag 9.
  - With `PIXEL_FIFO_DROP_CNT_EN` defined: `drop_cnt=1`.
- **Simultaneous push and pop.** FIFO full, `out_ready=1` on the push edge.
  - Required: the push is accepted, count stays 8, `overflow` stays 0.
- **Sequence errors.**
  - `read_2` phase with no prior `read_1`: one-cycle `seq_err`, no push.
  - Two `read_1` phases with values 16'h0001 then 16'h0002, followed by `read_2`: `seq_err` pulses once and `out_data[15:0]=16'h0002`.
- **Reset mid-operation.** Assert `reset` for one cycle while in HAVE_P1 with 3 entries queued.
  - Required: the next cycle shows `out_valid=0`, `full=0`, `overflow=0`.
  - Required: the next complete frame has tag 0.

Source files
------------

// File: rtl/pixel_readout_fifo.sv
// Pairs the read_1/read_2 pixel samples into 32-bit words and queues them with a frame tag.
// Optional `PIXEL_FIFO_DROP_CNT_EN adds a saturating count of dropped pairs on drop_cnt.
module pixel_readout_fifo #(
   parameter int DEPTH   = 8,
   parameter int FRAME_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               read_1,
   input  logic               read_2,
   input  logic [15:0]        pixdata1,
   input  logic [15:0]        pixdata2,
   output logic [31:0]        out_data,
   output logic [FRAME_W-1:0] out_frame,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               full,
   output logic               overflow,
   output logic               seq_err
`ifdef PIXEL_FIFO_DROP_CNT_EN
   ,
   output logic [15:0]        drop_cnt
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic {IDLE, HAVE_P1} state_t;

   state_t             state;
   logic               r1_d, r2_d;
   logic [15:0]        h1, h2, p1;
   logic [AW-1:0]      rd_ptr, wr_ptr;
   logic [CW-1:0]      count, count_next;
   logic [FRAME_W-1:0] frame_cnt;
   logic [31:0]        mem_data  [DEPTH];
   logic [FRAME_W-1:0] mem_frame [DEPTH];

   logic fall1, fall2, pop, push_req, push_ok, drop;

   assign fall1    = r1_d & ~read_1;
   assign fall2    = r2_d & ~read_2;
   assign pop      = out_valid & out_ready;
   // A full FIFO still accepts a push when the head leaves on the same edge.
   assign push_req = (state == HAVE_P1) & fall2 & ~fall1;
   assign push_ok  = push_req & ((count != DEPTH_C) | pop);
   assign drop     = push_req & ~push_ok;

   always_comb begin
      count_next = count;
      if (push_ok && !pop)
         count_next = count + CW'(1);
      else if (pop && !push_ok)
         count_next = count - CW'(1);
   end

   assign out_data  = out_valid ? mem_data[rd_ptr]  : '0;
   assign out_frame = out_valid ? mem_frame[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_data[wr_ptr]  <= {h2, p1};
         mem_frame[wr_ptr] <= frame_cnt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         r1_d      <= 1'b0;
         r2_d      <= 1'b0;
         h1        <= '0;
         h2        <= '0;
         p1        <= '0;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         frame_cnt <= '0;
         out_valid <= 1'b0;
         full      <= 1'b0;
         overflow  <= 1'b0;
         seq_err   <= 1'b0;
      end else begin
         r1_d    <= read_1;
         r2_d    <= read_2;
         seq_err <= 1'b0;
         if (read_1) h1 <= pixdata1;
         if (read_2) h2 <= pixdata2;

         if (fall1 && fall2) begin
            seq_err <= 1'b1;
            state   <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (fall1) begin
                     p1    <= h1;
                     state <= HAVE_P1;
                  end else if (fall2) begin
                     seq_err <= 1'b1;
                  end
               end
               HAVE_P1: begin
                  // The tag advances even when the pair is dropped, exposing the gap.
                  if (fall2) begin
                     frame_cnt <= frame_cnt + FRAME_W'(1);
                     state     <= IDLE;
                  end else if (fall1) begin
                     seq_err <= 1'b1;
                     p1      <= h1;
                  end
               end
               default: state <= IDLE;
            endcase
         end

         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop)     rd_ptr <= rd_ptr + AW'(1);
         if (drop)    overflow <= 1'b1;

         count     <= count_next;
         out_valid <= (count_next != '0);
         full      <= (count_next == DEPTH_C);
      end
   end

`ifdef PIXEL_FIFO_DROP_CNT_EN
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_ff @(posedge clk) begin
      if (reset)
         drop_cnt <= '0;
      else if (drop)
         drop_cnt <= sat_inc16(drop_cnt);
   end
`endif

endmodule

// File: tb/tb_pixel_readout_fifo.sv
// Bench for pixel_readout_fifo: table-driven frames, a tag/data scoreboard and corner sequences.
// Honours `PIXEL_FIFO_DROP_CNT_EN to also check drop_cnt.
module tb_pixel_readout_fifo;

   localparam int DEPTH   = 8;
   localparam int FRAME_W = 8;

   logic               clk = 1'b0;
   logic               reset;
   logic               read_1, read_2;
   logic [15:0]        pixdata1, pixdata2;
   logic [31:0]        out_data;
   logic [FRAME_W-1:0] out_frame;
   logic               out_valid, out_ready, full, overflow, seq_err;
`ifdef PIXEL_FIFO_DROP_CNT_EN
   logic [15:0]        drop_cnt;
`endif

   pixel_readout_fifo #(.DEPTH(DEPTH), .FRAME_W(FRAME_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .read_1    (read_1),
      .read_2    (read_2),
      .pixdata1  (pixdata1),
      .pixdata2  (pixdata2),
      .out_data  (out_data),
      .out_frame (out_frame),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .full      (full),
      .overflow  (overflow),
      .seq_err   (seq_err)
`ifdef PIXEL_FIFO_DROP_CNT_EN
      ,
      .drop_cnt  (drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]        data;
      logic [FRAME_W-1:0] frame;
   } sb_t;

   typedef struct {
      logic [15:0] p1;
      logic [15:0] p2;
      int          hold;
      logic [31:0] exp_data;
   } vec_t;

   sb_t                sb[$];
   vec_t               vecs[DEPTH];
   logic [FRAME_W-1:0] exp_frame;
   int                 total = 0;
   int                 passed = 0;
   int                 seq_seen = 0;

   always @(negedge clk) if (seq_err === 1'b1) seq_seen++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, required %0h", name, act, exp);
   endtask

   task automatic do_reset();
      reset = 1'b1; read_1 = 1'b0; read_2 = 1'b0; out_ready = 1'b0;
      pixdata1 = '0; pixdata2 = '0;
      tick(); tick();
      reset = 1'b0;
      sb.delete();
      exp_frame = '0;
   endtask

   // One well-formed frame; optionally pops the head on the push edge.
   task automatic frame(input logic [15:0] a, input logic [15:0] b, input int n,
                        input logic [31:0] exp_data, input bit pop_at_push);
      sb_t e;
      read_1 = 1'b1; pixdata1 = a;
      repeat (n) tick();
      read_1 = 1'b0;
      tick();
      read_2 = 1'b1; pixdata2 = b;
      repeat (n) tick();
      read_2 = 1'b0;
      check("valid_before_push", out_valid, (sb.size() != 0));
      if (pop_at_push) begin
         out_ready = 1'b1;
         e = sb.pop_front();
         check("pop_at_push_data", out_data, e.data);
         check("pop_at_push_tag", out_frame, e.frame);
      end
      if (sb.size() < DEPTH) sb.push_back('{exp_data, exp_frame});
      exp_frame++;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic drain();
      sb_t e;
      out_ready = 1'b1;
      for (int k = 0; k < DEPTH + 2 && sb.size() > 0; k++) begin
         e = sb.pop_front();
         check("drain_valid", out_valid, 1'b1);
         check("drain_data", out_data, e.data);
         check("drain_tag", out_frame, e.frame);
         tick();
      end
      out_ready = 1'b0;
      check("drain_bound", sb.size(), 0);
      check("empty_after_drain", out_valid, 1'b0);
   endtask

   initial begin
      int base;
      vecs[0] = '{16'h0001, 16'h1000, 1, 32'h1000_0001};
      vecs[1] = '{16'h00FF, 16'hFF00, 2, 32'hFF00_00FF};
      vecs[2] = '{16'hFFFF, 16'h0000, 3, 32'h0000_FFFF};
      vecs[3] = '{16'h0000, 16'hFFFF, 1, 32'hFFFF_0000};
      vecs[4] = '{16'hA5A5, 16'h5A5A, 2, 32'h5A5A_A5A5};
      vecs[5] = '{16'h8000, 16'h0001, 4, 32'h0001_8000};
      vecs[6] = '{16'hCAFE, 16'hBEEF, 1, 32'hBEEF_CAFE};
      vecs[7] = '{16'h7FFF, 16'h8001, 2, 32'h8001_7FFF};

      do_reset();
      check("rst_out_data", out_data, 32'h0);
      check("rst_out_frame", out_frame, 8'h0);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_full", full, 1'b0);
      check("rst_overflow", overflow, 1'b0);
      check("rst_seq_err", seq_err, 1'b0);

      // Basic frame
      frame(16'h1234, 16'hABCD, 5, 32'hABCD_1234, 1'b0);
      check("basic_valid", out_valid, 1'b1);
      check("basic_data", out_data, 32'hABCD_1234);
      check("basic_tag", out_frame, 8'd0);
      drain();

      // Last-sample hold: the final value of the ramp is paired
      read_1 = 1'b1;
      pixdata1 = 16'd0;   tick();
      pixdata1 = 16'd257; tick();
      pixdata1 = 16'd514; tick();
      read_1 = 1'b0; pixdata1 = 16'hDEAD; tick();
      read_2 = 1'b1; pixdata2 = 16'h5555; tick(); tick();
      read_2 = 1'b0;
      sb.push_back('{32'h5555_0202, exp_frame});
      exp_frame++;
      tick();
      check("hold_low_half", out_data[15:0], 16'd514);
      drain();

      // Fill to full, then drop a ninth pair
      do_reset();
      for (int i = 0; i < DEPTH; i++)
         frame(vecs[i].p1, vecs[i].p2, vecs[i].hold, vecs[i].exp_data, 1'b0);
      check("fill_full", full, 1'b1);
      check("fill_no_overflow", overflow, 1'b0);
      frame(16'h9999, 16'h8888, 2, 32'h8888_9999, 1'b0);
      check("drop_overflow", overflow, 1'b1);
      check("drop_head_tag", out_frame, 8'd0);
      check("drop_still_full", full, 1'b1);
`ifdef PIXEL_FIFO_DROP_CNT_EN
      check("drop_cnt", drop_cnt, 16'd1);
`endif
      drain();
      check("drop_sticky", overflow, 1'b1);
      frame(16'h0A0A, 16'h0B0B, 1, 32'h0B0B_0A0A, 1'b0);
      check("after_drop_tag", out_frame, 8'd9);
      drain();

      // Simultaneous push and pop while full
      do_reset();
      check("rst2_overflow", overflow, 1'b0);
      for (int i = 0; i < DEPTH; i++)
         frame(vecs[i].p1, vecs[i].p2, 1, vecs[i].exp_data, 1'b0);
      frame(16'h4321, 16'h8765, 2, 32'h8765_4321, 1'b1);
      check("pushpop_full", full, 1'b1);
      check("pushpop_overflow", overflow, 1'b0);
      check("pushpop_head_tag", out_frame, 8'd1);
      drain();

      // read_2 with no preceding read_1
      read_2 = 1'b1; pixdata2 = 16'h3333;
      repeat (3) tick();
      read_2 = 1'b0;
      tick();
      check("orphan_seq_err", seq_err, 1'b1);
      tick();
      check("orphan_seq_err_pulse", seq_err, 1'b0);
      check("orphan_no_push", out_valid, 1'b0);

      // Two read_1 phases before read_2: second value wins
      base = seq_seen;
      read_1 = 1'b1; pixdata1 = 16'h0001; tick(); tick();
      read_1 = 1'b0; tick();
      read_1 = 1'b1; pixdata1 = 16'h0002; tick(); tick();
      read_1 = 1'b0; tick();
      read_2 = 1'b1; pixdata2 = 16'h7777; tick(); tick();
      read_2 = 1'b0;
      sb.push_back('{32'h7777_0002, exp_frame});
      exp_frame++;
      tick(); tick();
      check("double_r1_seq_pulses", seq_seen - base, 1);
      check("double_r1_low_half", out_data[15:0], 16'h0002);
      drain();

      // Reset while in HAVE_P1 with 3 entries queued
      for (int i = 0; i < 3; i++)
         frame(vecs[i].p1, vecs[i].p2, 1, vecs[i].exp_data, 1'b0);
      read_1 = 1'b1; pixdata1 = 16'h6666; tick(); tick();
      read_1 = 1'b0; tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midrst_valid", out_valid, 1'b0);
      check("midrst_full", full, 1'b0);
      check("midrst_overflow", overflow, 1'b0);
      sb.delete();
      exp_frame = '0;
      read_2 = 1'b1; pixdata2 = 16'h1111; tick(); tick();
      read_2 = 1'b0; tick(); tick();
      check("midrst_pair_discarded", out_valid, 1'b0);
      frame(16'h2468, 16'h1357, 2, 32'h1357_2468, 1'b0);
      check("midrst_tag0", out_frame, 8'd0);
      drain();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish, required finish before 200000");
      $fatal(1);
   end

endmodule
